// File: rtl/typed_ndata_packet_scheduler.sv
// Packet-granular round-robin scheduler driving the select stream of the typed
// N-way data multiplexer, with a per-grant packet quota before priority rotates.
module typed_ndata_packet_scheduler #(
  parameter int NUM_STREAMS = 4,
  parameter int QUANTUM     = 1,
  parameter int IDX_W       = $clog2(NUM_STREAMS)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_STREAMS-1:0] req_valid_i,
  input  logic [NUM_STREAMS-1:0] enable_i,
  output logic                   select_valid_o,
  output logic [IDX_W-1:0]       select_data_o,
  input  logic                   select_ready_i,
  output logic                   busy_o,
  output logic [31:0]            pkt_count_o
);

  localparam int CNT_W = (QUANTUM < 1) ? 1 : $clog2(QUANTUM + 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e           state_q;
  logic             sel_valid_q;
  logic [IDX_W-1:0] sel_data_q;
  logic [IDX_W-1:0] last_idx_q;
  logic [CNT_W-1:0] q_cnt_q;
  logic [31:0]      pkt_count_q;

  logic [NUM_STREAMS-1:0] elig;
  logic [IDX_W-1:0]       rr_idx;
  logic [IDX_W-1:0]       scan_idx;
  logic                   rr_found;
  logic                   keep_d;
  logic [IDX_W-1:0]       choice_d;
  logic [CNT_W-1:0]       q_cnt_d;
  logic [31:0]            pkt_count_d;

  always_comb begin
    elig     = req_valid_i & enable_i;
    rr_idx   = '0;
    scan_idx = '0;
    rr_found = 1'b0;
    // Cyclic scan starting just after the last grant; the last grant itself is
    // visited last, so it only wins when it is the sole eligible stream.
    for (int k = 1; k <= NUM_STREAMS; k++) begin
      scan_idx = IDX_W'((int'(last_idx_q) + k) % NUM_STREAMS);
      if (!rr_found && elig[scan_idx]) begin
        rr_found = 1'b1;
        rr_idx   = scan_idx;
      end
    end
    keep_d      = (q_cnt_q != '0) && (q_cnt_q < CNT_W'(QUANTUM)) && elig[last_idx_q];
    choice_d    = keep_d ? last_idx_q : rr_idx;
    q_cnt_d     = (q_cnt_q >= CNT_W'(QUANTUM)) ? CNT_W'(QUANTUM) : q_cnt_q + 1'b1;
    pkt_count_d = (&pkt_count_q) ? pkt_count_q : pkt_count_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      sel_valid_q <= 1'b0;
      sel_data_q  <= '0;
      last_idx_q  <= IDX_W'(NUM_STREAMS - 1);
      q_cnt_q     <= '0;
      pkt_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|elig) begin
            sel_valid_q <= 1'b1;
            sel_data_q  <= choice_d;
            last_idx_q  <= choice_d;
            if (!keep_d) q_cnt_q <= '0;
            state_q     <= GRANT;
          end
        end
        GRANT: begin
          // Grant is held regardless of req/enable; only packet end releases it.
          if (select_ready_i) begin
            sel_valid_q <= 1'b0;
            q_cnt_q     <= q_cnt_d;
            pkt_count_q <= pkt_count_d;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign select_valid_o = sel_valid_q;
  assign select_data_o  = sel_data_q;
  assign busy_o         = sel_valid_q;
  assign pkt_count_o    = pkt_count_q;

endmodule

// File: tb/tb_typed_ndata_packet_scheduler.sv
// Scoreboard bench: expected grant indices are queued per scenario and popped
// as each new grant appears on the observed scheduler instance.
module tb_typed_ndata_packet_scheduler;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, which, rdy;
  logic [3:0]  req, en;
  logic        v_rr, v_q3, b_rr, b_q3;
  logic [1:0]  d_rr, d_q3;
  logic [31:0] pc_rr, pc_q3;
  logic        rdy_rr, rdy_q3;
  logic        obs_v, obs_b;
  logic [1:0]  obs_d;
  logic [31:0] obs_pc;

  assign rdy_rr = rdy & ~which;
  assign rdy_q3 = rdy & which;
  assign obs_v  = which ? v_q3  : v_rr;
  assign obs_b  = which ? b_q3  : b_rr;
  assign obs_d  = which ? d_q3  : d_rr;
  assign obs_pc = which ? pc_q3 : pc_rr;

  typed_ndata_packet_scheduler #(.NUM_STREAMS(4), .QUANTUM(1)) u_rr (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req), .enable_i(en),
    .select_valid_o(v_rr), .select_data_o(d_rr), .select_ready_i(rdy_rr),
    .busy_o(b_rr), .pkt_count_o(pc_rr));

  typed_ndata_packet_scheduler #(.NUM_STREAMS(4), .QUANTUM(3)) u_q3 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req), .enable_i(en),
    .select_valid_o(v_q3), .select_data_o(d_q3), .select_ready_i(rdy_q3),
    .busy_o(b_q3), .pkt_count_o(pc_q3));

  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_q[$];
  logic [31:0] exp_pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rdy = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_valid", {31'd0, obs_v}, 0);
      chk("rst_pkt_count", obs_pc, 0);
    end
    rst = 1'b0;
    exp_pc = '0;
    exp_q.delete();
  endtask

  // Serve n packets: wait for grant, compare against scoreboard, optionally hold
  // the grant while clearing the granted stream's enable, then pulse ready.
  task automatic serve(input int n, input int hold, input bit gap_chk);
    for (int i = 0; i < n; i++) begin
      int w = 0;
      int e;
      while (!obs_v && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (!obs_v) begin
        chk("grant_timeout", 0, 1);
        return;
      end
      if (gap_chk && i > 0) chk("bubble_cycles", w, 1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      chk("grant_idx", {30'd0, obs_d}, e);
      chk("busy_hi", {31'd0, obs_b}, 1);
      if (hold > 0) begin
        en[e[1:0]] = 1'b0;
        repeat (hold) begin
          @(negedge clk);
          chk("hold_data", {30'd0, obs_d}, e);
          chk("hold_valid", {31'd0, obs_v}, 1);
        end
      end
      rdy = 1'b1;
      @(negedge clk);
      rdy = 1'b0;
      exp_pc = (&exp_pc) ? exp_pc : exp_pc + 32'd1;
      chk("drop_valid", {31'd0, obs_v}, 0);
      chk("busy_lo", {31'd0, obs_b}, 0);
      chk("pkt_count", obs_pc, exp_pc);
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b0; which = 1'b0;
    req = 4'b1111; en = 4'b1111; exp_pc = '0;
    @(negedge clk);

    // Reset, first grant, then plain packet round-robin
    do_reset();
    @(negedge clk);
    chk("first_valid", {31'd0, obs_v}, 1);
    chk("first_data", {30'd0, obs_d}, 0);
    exp_q = '{0, 1, 2, 3, 0};
    serve(5, 0, 1);
    chk("rr_pkt_total", obs_pc, 5);

    // Quota of three packets per grant
    which = 1'b1;
    req = 4'b0110;
    do_reset();
    exp_q = '{1, 1, 1, 2, 2, 2, 1};
    serve(7, 0, 1);

    // Enable mask excludes stream 2; clearing enable mid-grant holds the grant
    which = 1'b0;
    req = 4'b1111; en = 4'b1011;
    do_reset();
    exp_q = '{0, 1, 3, 0, 1};
    serve(5, 0, 1);
    exp_q = '{3};
    serve(1, 3, 0);
    exp_q = '{0};
    serve(1, 0, 0);

    // Stray ready while idle
    req = 4'b0000;
    @(negedge clk);
    rdy = 1'b1;
    repeat (2) @(negedge clk);
    rdy = 1'b0;
    chk("stray_pkt_count", obs_pc, exp_pc);
    chk("stray_valid", {31'd0, obs_v}, 0);

    // Reset colliding with ready in a grant cycle
    req = 4'b1111; en = 4'b1111;
    begin
      int w = 0;
      while (!obs_v && w < 20) begin
        @(negedge clk);
        w++;
      end
      chk("coll_granted", {31'd0, obs_v}, 1);
    end
    rst = 1'b1; rdy = 1'b1; req = 4'b0000;
    @(negedge clk);
    chk("coll_pkt_count", obs_pc, 0);
    chk("coll_valid", {31'd0, obs_v}, 0);
    chk("coll_data", {30'd0, obs_d}, 0);
    rst = 1'b0; rdy = 1'b0;
    @(negedge clk);
    chk("coll_idle", {31'd0, obs_v}, 0);
    exp_q.delete();

    // Saturation from a preloaded count
    force u_rr.pkt_count_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release u_rr.pkt_count_q;
    @(negedge clk);
    chk("sat_preload", obs_pc, 32'hFFFF_FFFE);
    exp_pc = 32'hFFFF_FFFE;
    req = 4'b1111;
    exp_q = '{0, 1, 2};
    serve(3, 0, 1);
    chk("sat_final", obs_pc, 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
